read_reorder_buffer: RTL and testbench
======================================

Name: read_reorder_buffer

Overview:
Reorder buffer (ROB) downstream of the tag comparator's read-hit path. Read transaction IDs (TIDs) are allocated in host request order at issue time. Full cache lines arrive out of order on a write port as {tid, line}. The block returns each line to the host AXI R channel as a TOTAL_CYCLE-beat burst, strictly in allocation order, with the host ARID captured at allocation.

Parameters:
ID_WIDTH, 4, host AXI ID width
TID_WIDTH, 4, TID width; DEPTH = 2**TID_WIDTH entries
BURST_SIZE, 64, bits per R beat
TOTAL_CYCLE, 8, beats per cache line

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
alloc_valid_i  in  1  allocation request from issue stage
alloc_id_i  in  ID_WIDTH  host ARID for the new entry
alloc_ready_o  out  1  entry available
alloc_tid_o  out  TID_WIDTH  TID granted; valid while alloc_ready_o=1
wren_i  in  1  line write from tag comparator (read hit)
data_i  in  TID_WIDTH+BURST_SIZE*TOTAL_CYCLE  {tid (MSBs), line}
afull_o  out  1  write-port almost-full
rid_o  out  ID_WIDTH  host R ID
rdata_o  out  BURST_SIZE  host R data
rresp_o  out  2  host R response, constant 2'b00
rlast_o  out  1  last beat of burst
rvalid_o  out  1  R valid
rready_i  in  1  R ready

Behaviour:
- Reset values: rvalid_o=0, rlast_o=0, rdata_o=0, rid_o=0, afull_o=1. Internally head=tail=count=0 and all entries have allocated=0 and filled=0. Reset takes effect at the first edge with rst_n=0.
- afull_o: registered; reads 1 during reset; 0 from the first edge with rst_n=1. Every write targets a pre-allocated slot, so the write port never overflows.
- Allocation:
  - alloc_ready_o = (count < DEPTH), decoded from registered count.
  - alloc_tid_o = tail.
  - On alloc_valid_i && alloc_ready_o: entry[tail].id <= alloc_id_i; allocated<=1; filled<=0; tail <= tail+1 modulo DEPTH; count++.
- Write:
  - On wren_i: tid = data_i[top TID_WIDTH bits]; entry[tid].line <= lower bits; filled<=1.
  - A write to an entry with allocated=0, or one already filled, is dropped with no state change.
- Drain FSM, states S_IDLE and S_SEND:
  - S_IDLE: if entry[head] has allocated && filled, load line and id into the output shift register, set beat=0, rvalid_o<=1, rlast_o<=(TOTAL_CYCLE==1), go to S_SEND.
  - S_SEND, on rvalid_o && rready_i:
    - If not the last beat: beat++ and present the next beat.
    - If beat==TOTAL_CYCLE-1: rvalid_o<=0, rlast_o<=0; entry[head] allocated<=0 and filled<=0; head++ (wrap); count--; go to S_IDLE. One bubble cycle follows between bursts.
  - Beat order: beat k = line[BURST_SIZE*(TOTAL_CYCLE-k)-1 : BURST_SIZE*(TOTAL_CYCLE-k-1)], so beat 0 is the most significant slice.
  - rlast_o=1 exactly on beat TOTAL_CYCLE-1.
- AXI rule: while rvalid_o && !rready_i, rid_o, rdata_o and rlast_o hold stable.
- Latency: wren_i sampled at edge E to the head entry gives rvalid_o=1 after edge E+1.
- Simultaneous events:
  - Allocation and free in the same cycle: count unchanged.
  - At full, a free does not enable allocation in that same cycle; alloc_ready_o rises on the next cycle.
  - A write landing on head while the FSM is in S_IDLE is seen on the next cycle.
  - An allocation reusing a slot freed on that same edge is impossible, because alloc_ready_o is registered.
- Reset mid-burst: all state clears; rvalid_o=0 after the reset edge; the partial burst is abandoned.

Decomposition:
- AXI_TYPEDEF.svh, as shared constants: ID_WIDTH, TID_WIDTH, BURST_SIZE, TOTAL_CYCLE, and the ROB write-word layout (tid at MSBs).
- Packed struct rob_entry_t {allocated, filled, id, line} in the shared package.
- One natural sub-module: rob_line_serializer, taking a line plus id and producing the R beats with valid/ready and rlast.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> rvalid_o=0, afull_o=1, alloc_ready_o=1, alloc_tid_o=0. After release -> afull_o=0.
- Single read: allocate with id=3 (granted tid=0); write tid 0 with beat k = 64'hk, k=0..7 -> 8 beats with rid=3, data 0..7, rlast only on the 8th, rvalid_o high after edge E+1.
- Out-of-order fill: allocate ids 5,6,7 (tids 0,1,2); write tid2, then tid1, then tid0 -> no rvalid_o until tid0 is written; bursts emerge with rid 5, 6, 7 in that order.
- Backpressure: rready_i pattern 1,0,1,0,... during a burst -> rdata_o/rlast_o stable on every stalled cycle; all 8 beats delivered, none lost or duplicated.
- Full and wrap: 16 allocations without writes -> alloc_ready_o=0 after the 16th. Write and drain tid0 -> alloc_ready_o=1 one cycle after the free; the next grant is tid=0.
- Mid-burst reset: assert rst_n=0 after beat 3 -> rvalid_o=0; the next allocation grants tid=0; a stale write to tid1 is dropped with no output.

Source files
------------

// File: rtl/read_reorder_buffer_pkg.sv
// Shared constants, write-word layout and entry type for the read reorder buffer.
package read_reorder_buffer_pkg;

  localparam int unsigned ID_WIDTH    = 4;
  localparam int unsigned TID_WIDTH   = 4;
  localparam int unsigned BURST_SIZE  = 64;
  localparam int unsigned TOTAL_CYCLE = 8;

  localparam int unsigned DEPTH  = 2 ** TID_WIDTH;
  localparam int unsigned LINE_W = BURST_SIZE * TOTAL_CYCLE;
  localparam int unsigned DATA_W = TID_WIDTH + LINE_W;
  localparam int unsigned CNT_W  = TID_WIDTH + 1;
  localparam int unsigned BEAT_W = (TOTAL_CYCLE > 1) ? $clog2(TOTAL_CYCLE) : 1;

  typedef struct packed {
    logic                allocated;
    logic                filled;
    logic [ID_WIDTH-1:0] id;
    logic [LINE_W-1:0]   line;
  } rob_entry_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } drain_state_t;

  // Write word is {tid, line} with the TID in the most significant bits.
  function automatic logic [TID_WIDTH-1:0] wr_word_tid(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: TID_WIDTH];
  endfunction

  function automatic logic [LINE_W-1:0] wr_word_line(input logic [DATA_W-1:0] w);
    return w[LINE_W-1:0];
  endfunction

endpackage

// File: rtl/rob_line_serializer.sv
// Turns one cache line plus its host ID into a TOTAL_CYCLE-beat AXI R burst,
// most significant slice first, with registered valid/last/data/id.
module rob_line_serializer
  import read_reorder_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_ready,
  input  logic [LINE_W-1:0]     line,
  input  logic [ID_WIDTH-1:0]   id,
  output logic                  done_c,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [BURST_SIZE-1:0] rdata,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);

  drain_state_t      state;
  logic [BEAT_W-1:0] beat;
  logic [LINE_W-1:0] shreg;
  logic              last_beat_c;

  assign last_beat_c = (beat == BEAT_W'(TOTAL_CYCLE - 1));
  assign done_c      = (state == S_SEND) && rvalid && rready && last_beat_c;

  // Drain FSM; outputs only move on an accepted beat so they hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      beat   <= '0;
      shreg  <= '0;
      rid    <= '0;
      rdata  <= '0;
      rlast  <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (line_ready) begin
            rid    <= id;
            rdata  <= line[LINE_W-1 -: BURST_SIZE];
            shreg  <= line << BURST_SIZE;
            beat   <= '0;
            rvalid <= 1'b1;
            rlast  <= (TOTAL_CYCLE == 1);
            state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (rvalid && rready) begin
            if (last_beat_c) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              state  <= S_IDLE;
            end else begin
              beat  <= beat + BEAT_W'(1);
              rdata <= shreg[LINE_W-1 -: BURST_SIZE];
              shreg <= shreg << BURST_SIZE;
              rlast <= (beat == BEAT_W'(TOTAL_CYCLE - 2));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/read_reorder_buffer.sv
// Read reorder buffer: TIDs allocated in host order, lines filled out of order,
// returned to the host R channel as bursts strictly in allocation order.
module read_reorder_buffer
  import read_reorder_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid_i,
  input  logic [ID_WIDTH-1:0]   alloc_id_i,
  output logic                  alloc_ready_o,
  output logic [TID_WIDTH-1:0]  alloc_tid_o,
  input  logic                  wren_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic                  afull_o,
  output logic [ID_WIDTH-1:0]   rid_o,
  output logic [BURST_SIZE-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic                  rvalid_o,
  input  logic                  rready_i
);

  logic [DEPTH-1:0]    allocated;
  logic [DEPTH-1:0]    filled;
  logic [ID_WIDTH-1:0] ids   [DEPTH];
  logic [LINE_W-1:0]   lines [DEPTH];

  logic [TID_WIDTH-1:0] head;
  logic [TID_WIDTH-1:0] tail;
  logic [CNT_W-1:0]     count;

  logic                 alloc_fire_c;
  logic                 free_c;
  logic                 wr_ok_c;
  logic [TID_WIDTH-1:0] wr_tid_c;
  logic [LINE_W-1:0]    wr_line_c;
  rob_entry_t           head_entry_c;

  assign alloc_ready_o = (count < CNT_W'(DEPTH));
  assign alloc_tid_o   = tail;
  assign alloc_fire_c  = alloc_valid_i && alloc_ready_o;
  assign rresp_o       = 2'b00;

  assign wr_tid_c  = wr_word_tid(data_i);
  assign wr_line_c = wr_word_line(data_i);
  // Writes only land on a slot that is allocated and still empty.
  assign wr_ok_c   = wren_i && allocated[wr_tid_c] && !filled[wr_tid_c];

  assign head_entry_c = '{allocated: allocated[head],
                          filled:    filled[head],
                          id:        ids[head],
                          line:      lines[head]};

  // Per-entry status flags; free, allocate and fill never hit the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      allocated <= '0;
      filled    <= '0;
    end else begin
      if (free_c) begin
        allocated[head] <= 1'b0;
        filled[head]    <= 1'b0;
      end
      if (alloc_fire_c) begin
        allocated[tail] <= 1'b1;
        filled[tail]    <= 1'b0;
      end
      if (wr_ok_c) begin
        filled[wr_tid_c] <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: it is only read once the flags say so.
  always_ff @(posedge clk) begin
    if (alloc_fire_c) begin
      ids[tail] <= alloc_id_i;
    end
    if (wr_ok_c) begin
      lines[wr_tid_c] <= wr_line_c;
    end
  end

  // Ring pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      afull_o <= 1'b1;
    end else begin
      afull_o <= 1'b0;
      if (alloc_fire_c) begin
        tail <= tail + TID_WIDTH'(1);
      end
      if (free_c) begin
        head <= head + TID_WIDTH'(1);
      end
      case ({alloc_fire_c, free_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  rob_line_serializer u_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_ready (head_entry_c.allocated && head_entry_c.filled),
    .line       (head_entry_c.line),
    .id         (head_entry_c.id),
    .done_c     (free_c),
    .rid        (rid_o),
    .rdata      (rdata_o),
    .rlast      (rlast_o),
    .rvalid     (rvalid_o),
    .rready     (rready_i)
  );

endmodule

// File: tb/tb_read_reorder_buffer.sv
// Scoreboard bench for read_reorder_buffer: a queue-based reference model predicts
// the R beat stream; a negedge monitor checks every accepted and stalled beat.
module tb_read_reorder_buffer;
  import read_reorder_buffer_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  alloc_valid = 1'b0;
  logic [ID_WIDTH-1:0]   alloc_id = '0;
  logic                  alloc_ready;
  logic [TID_WIDTH-1:0]  alloc_tid;
  logic                  wren = 1'b0;
  logic [DATA_W-1:0]     data = '0;
  logic                  afull;
  logic [ID_WIDTH-1:0]   rid;
  logic [BURST_SIZE-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready = 1'b1;

  read_reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_id_i(alloc_id),
    .alloc_ready_o(alloc_ready), .alloc_tid_o(alloc_tid),
    .wren_i(wren), .data_i(data), .afull_o(afull),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
    .rvalid_o(rvalid), .rready_i(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_WIDTH-1:0]   id;
    logic [BURST_SIZE-1:0] data;
    logic                  last;
    int                    tid;
  } beat_t;

  beat_t               exp_q[$];
  int                  order_q[$];
  logic [ID_WIDTH-1:0] m_id   [DEPTH];
  logic [LINE_W-1:0]   m_line [DEPTH];
  bit                  m_alloc[DEPTH];
  bit                  m_fill [DEPTH];
  int                  m_tail = 0;
  int                  m_count = 0;

  int errors = 0;
  int checks = 0;
  int beats_seen = 0;
  int rmode = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    order_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_alloc[i] = 1'b0;
      m_fill[i]  = 1'b0;
    end
    m_tail  = 0;
    m_count = 0;
  endfunction

  // Release every line at the front of allocation order that has its data.
  function automatic void pump();
    while (order_q.size() > 0 && m_fill[order_q[0]]) begin
      int t;
      t = order_q.pop_front();
      for (int k = 0; k < TOTAL_CYCLE; k++) begin
        beat_t b;
        b.id   = m_id[t];
        b.data = m_line[t][LINE_W-1-BURST_SIZE*k -: BURST_SIZE];
        b.last = (k == TOTAL_CYCLE - 1);
        b.tid  = t;
        exp_q.push_back(b);
      end
    end
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic do_alloc(input logic [ID_WIDTH-1:0] id);
    int n;
    n = 0;
    alloc_valid = 1'b1;
    alloc_id    = id;
    @(negedge clk);
    while (!alloc_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("alloc_ready", 64'(alloc_ready), 64'd1);
    check("alloc_tid", 64'(alloc_tid), 64'(m_tail));
    @(posedge clk);
    if (alloc_ready) begin
      m_id[m_tail]    = id;
      m_alloc[m_tail] = 1'b1;
      m_fill[m_tail]  = 1'b0;
      order_q.push_back(m_tail);
      m_tail  = (m_tail + 1) % DEPTH;
      m_count++;
    end
    #1;
    alloc_valid = 1'b0;
  endtask

  task automatic do_write(input int tid, input logic [LINE_W-1:0] line);
    wren = 1'b1;
    data = {TID_WIDTH'(tid), line};
    @(posedge clk);
    if (m_alloc[tid] && !m_fill[tid]) begin
      m_fill[tid] = 1'b1;
      m_line[tid] = line;
      pump();
    end
    #1;
    wren = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    idle(cycles);
    rst_n = 1'b1;
    idle(1);
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       rready = 1'b1;
      1:       rready = ~rready;
      2:       rready = 1'($urandom_range(0, 1));
      default: rready = 1'b0;
    endcase
  end

  logic                  stalled = 1'b0;
  logic [ID_WIDTH-1:0]   s_rid;
  logic [BURST_SIZE-1:0] s_rdata;
  logic                  s_rlast;

  // Monitor: a beat is accepted at the next posedge when valid and ready are seen here.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_rvalid", 64'(rvalid), 64'd1);
        check("hold_rid", 64'(rid), 64'(s_rid));
        check("hold_rdata", rdata, s_rdata);
        check("hold_rlast", 64'(rlast), 64'(s_rlast));
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got rid %h rdata %h with no beat expected", rid, rdata);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("rid", 64'(rid), 64'(b.id));
          check("rdata", rdata, b.data);
          check("rlast", 64'(rlast), 64'(b.last));
          check("rresp", 64'(rresp), 64'd0);
          beats_seen++;
          if (b.last) begin
            m_alloc[b.tid] = 1'b0;
            m_fill[b.tid]  = 1'b0;
            m_count--;
          end
        end
      end
      stalled = rvalid && !rready;
      s_rid   = rid;
      s_rdata = rdata;
      s_rlast = rlast;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] line;
    int                tids[$];
    int                base;
    int                n;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_rid", 64'(rid), 64'd0);
    check("rst_afull", 64'(afull), 64'd1);
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_alloc_tid", 64'(alloc_tid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("afull_after_release", 64'(afull), 64'd0);
    idle(1);

    // Single line, beat k carries value k, plus write-to-valid latency.
    rmode = 0;
    do_alloc(4'd3);
    for (int k = 0; k < TOTAL_CYCLE; k++) line[LINE_W-1-BURST_SIZE*k -: BURST_SIZE] = 64'(k);
    do_write(0, line);
    @(negedge clk);
    check("latency_edge_e", 64'(rvalid), 64'd0);
    @(negedge clk);
    check("latency_edge_e1", 64'(rvalid), 64'd1);
    wait_drain();

    // Out-of-order fill: nothing may leave until the oldest entry is written.
    tids.delete();
    for (int i = 0; i < 3; i++) begin
      tids.push_back(m_tail);
      do_alloc(ID_WIDTH'(5 + i));
    end
    do_write(tids[2], rand_line());
    do_write(tids[1], rand_line());
    idle(6);
    @(negedge clk);
    check("ooo_no_early_rvalid", 64'(rvalid), 64'd0);
    idle(1);
    do_write(tids[0], rand_line());
    wait_drain();

    // Alternating backpressure.
    rmode = 1;
    n = m_tail;
    do_alloc(4'd9);
    do_write(n, rand_line());
    wait_drain();
    rmode = 0;
    idle(2);

    // Fill every slot, then free one and check the pointer wrap.
    do_reset(2);
    for (int i = 0; i < DEPTH; i++) do_alloc(ID_WIDTH'(i));
    @(negedge clk);
    check("full_alloc_ready", 64'(alloc_ready), 64'd0);
    idle(1);
    do_write(0, rand_line());
    @(negedge clk);
    check("full_alloc_ready_pre_free", 64'(alloc_ready), 64'd0);
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("alloc_ready_after_free", 64'(alloc_ready), 64'd1);
    idle(1);
    do_alloc(4'hE);
    rmode = 2;
    for (int i = 1; i <= DEPTH; i++) do_write(i % DEPTH, rand_line());
    wait_drain();
    rmode = 0;
    idle(2);

    // Reset in the middle of a burst.
    n = m_tail;
    do_alloc(4'hA);
    do_write(n, rand_line());
    base = beats_seen;
    n = 0;
    while (beats_seen < base + 4 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("midburst_beats_before_reset", 64'(beats_seen - base), 64'd4);
    #1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("midburst_rvalid_cleared", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    do_alloc(4'h2);
    do_write(1, rand_line());
    idle(15);
    @(negedge clk);
    check("stale_write_no_output", 64'(rvalid), 64'd0);
    idle(1);
    do_write(0, rand_line());
    wait_drain();

    // Randomised rounds with shuffled fills and duplicate writes.
    rmode = 2;
    for (int r = 0; r < 4; r++) begin
      int cnt;
      cnt = $urandom_range(1, 12);
      tids.delete();
      for (int i = 0; i < cnt; i++) begin
        tids.push_back(m_tail);
        do_alloc(ID_WIDTH'($urandom));
      end
      for (int i = cnt - 1; i > 0; i--) begin
        int j;
        int tmp;
        j = $urandom_range(0, i);
        tmp = tids[i];
        tids[i] = tids[j];
        tids[j] = tmp;
      end
      for (int i = 0; i < cnt; i++) begin
        do_write(tids[i], rand_line());
        idle($urandom_range(0, 6));
      end
      do_write(tids[0], rand_line());
      wait_drain();
    end
    rmode = 0;
    idle(10);
    check("final_model_count", 64'(m_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
